// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - muldiv_op_e    : operation encodings on op[2:0]
//   - muldiv_state_t : control FSM states
//   - MULDIV_WIDTH   : default operand width
//   - DIV0_LO        : quotient returned on divide-by-zero (all ones)
//   - MULDIV_LAT     : cycles from accepted start to the write strobe (WIDTH+2)
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_LAT   = MULDIV_WIDTH + 2;
  localparam logic [MULDIV_WIDTH-1:0] DIV0_LO = '1;

  // op[1:0] selects the operation, op[2] selects accumulate (MADD/MSUB family).
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between control and the multiply/divide unit.
//   master : issues start/op/operands/flush, receives busy and the HI/LO write port
//   slave  : the muldiv_unit side
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [WIDTH-1:0] hi_acc;
  logic [WIDTH-1:0] lo_acc;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi_result;
  logic [WIDTH-1:0] lo_result;
  logic             hi_we;
  logic             lo_we;

  modport master (
    output start, op, rs_val, rt_val, hi_acc, lo_acc, flush,
    input  busy, hi_result, lo_result, hi_we, lo_we
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_acc, lo_acc, flush,
    output busy, hi_result, lo_result, hi_we, lo_we
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// Datapath shared by multiply and divide: a 2*WIDTH shift register, an operand
// register and one WIDTH+1-bit adder/subtractor. Each enabled step performs
// either a right-shifting shift-add (multiply) or a left-shifting restoring
// subtract (divide).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : capture load_a into the low half (high half cleared) and load_b
//                into the operand register; has priority over step
//   load_a     : multiplier / dividend magnitude
//   load_b     : multiplicand / divisor magnitude
//   is_div     : selects restoring-divide step instead of shift-add
//   step       : perform one iteration
//   result     : shift register; product {hi,lo} or {remainder, quotient}
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_a,
  input  logic [WIDTH-1:0]   load_b,
  input  logic               is_div,
  input  logic               step,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] sr;
  logic [2*WIDTH-1:0] sr_nx;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   sum;

  always_comb begin
    // Partial remainder shifted left by one, pulling in the next dividend bit.
    rem_sh = {sr[2*WIDTH-1:WIDTH], sr[WIDTH-1]};
    if (is_div) begin
      // a - b as a + ~b + 1; the carry out of bit WIDTH+1 means "no borrow".
      add_a   = rem_sh;
      add_b   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, sr[2*WIDTH-1:WIDTH]};
      add_b   = {1'b0, opnd};
      add_cin = 1'b0;
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};

    if (is_div) begin
      if (sum[WIDTH+1]) sr_nx = {sum[WIDTH-1:0], sr[WIDTH-2:0], 1'b1};
      else              sr_nx = {rem_sh[WIDTH-1:0], sr[WIDTH-2:0], 1'b0};
    end else begin
      if (sr[0]) sr_nx = {sum[WIDTH:0], sr[WIDTH-1:1]};
      else       sr_nx = {1'b0, sr[2*WIDTH-1:1]};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      opnd <= '0;
    end else if (load) begin
      sr   <= {{WIDTH{1'b0}}, load_a};
      opnd <= load_b;
    end else if (step) begin
      sr   <= sr_nx;
    end
  end

  assign result = sr;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit feeding the register file HI/LO write port.
// One bit per cycle; the 64-bit result is written as a single HI+LO strobe
// WIDTH+2 cycles after an accepted start. Signed ops iterate on magnitudes and
// the FIX cycle applies sign correction (and accumulation when enabled).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : muldiv_if.slave -- start/op/rs_val/rt_val/hi_acc/lo_acc/flush in,
//                busy/hi_result/lo_result/hi_we/lo_we out
// Configuration:
//   MULDIV_MADD_EN : when defined, op[2]=1 selects MADD/MADDU/MSUB/MSUBU using
//                    {hi_acc,lo_acc}; when undefined such starts are ignored.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  muldiv_state_t state, state_nx;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               step;
  logic               in_signed, in_div, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic               rs_neg_q, rt_neg_q, div_q, div0_q;
  logic [WIDTH-1:0]   rs_q;
  logic [2*WIDTH-1:0] core_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
  logic [WIDTH-1:0]   hi_q, lo_q;

`ifdef MULDIV_MADD_EN
  logic               acc_en_q, acc_sub_q;
  logic [2*WIDTH-1:0] acc_q;
  assign accept = (state == S_IDLE) && bus.start;
`else
  logic unused_acc;
  assign unused_acc = ^{bus.hi_acc, bus.lo_acc};
  assign accept = (state == S_IDLE) && bus.start && !bus.op[2];
`endif

  // Operand decode at the accepting edge; op[0]=0 means signed.
  always_comb begin
    in_signed = !bus.op[0];
    in_div    = bus.op[1] && !bus.op[2];
    rs_neg    = in_signed && bus.rs_val[WIDTH-1];
    rt_neg    = in_signed && bus.rt_val[WIDTH-1];
    rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    step     = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = in_div ? S_DIV : S_MUL;
      S_MUL, S_DIV: begin
        step = 1'b1;
        if (cnt == LAST) state_nx = S_FIX;
      end
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Flush kills anything in flight; in IDLE it has no effect, so start wins.
    if (bus.flush && state != S_IDLE) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept)    cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
    end
  end

  // Operation context captured once at accept; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_neg_q  <= 1'b0;
      rt_neg_q  <= 1'b0;
      div_q     <= 1'b0;
      div0_q    <= 1'b0;
      rs_q      <= '0;
`ifdef MULDIV_MADD_EN
      acc_en_q  <= 1'b0;
      acc_sub_q <= 1'b0;
      acc_q     <= '0;
`endif
    end else if (accept) begin
      rs_neg_q  <= rs_neg;
      rt_neg_q  <= rt_neg;
      div_q     <= in_div;
      div0_q    <= in_div && (bus.rt_val == '0);
      rs_q      <= bus.rs_val;
`ifdef MULDIV_MADD_EN
      acc_en_q  <= bus.op[2];
      acc_sub_q <= bus.op[1];
      acc_q     <= {bus.hi_acc, bus.lo_acc};
`endif
    end
  end

  // Multiplier is shifted out of the low half, so it is load_a; the
  // multiplicand stays in the operand register.
  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .load_a (in_div ? rs_mag : rt_mag),
    .load_b (in_div ? rt_mag : rs_mag),
    .is_div (state == S_DIV),
    .step   (step),
    .result (core_res)
  );

  // FIX: sign correction, divide special cases, optional accumulate.
  always_comb begin
    prod = (rs_neg_q ^ rt_neg_q) ? -core_res : core_res;
`ifdef MULDIV_MADD_EN
    if (acc_en_q) prod = acc_sub_q ? (acc_q - prod) : (acc_q + prod);
`endif
    quo = core_res[WIDTH-1:0];
    rem = core_res[2*WIDTH-1:WIDTH];
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // The 0x80000000 / -1 case falls out as 0x80000000 with remainder 0.
    if (rs_neg_q ^ rt_neg_q) quo = -quo;
    if (rs_neg_q)            rem = -rem;
    if (div0_q) begin
      quo = '1;
      rem = rs_q;
    end
    if (div_q) {fix_hi, fix_lo} = {rem, quo};
    else       {fix_hi, fix_lo} = prod;
  end

  // Result registers load at FIX->DONE and hold until the next completed op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == S_FIX && !bus.flush) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.hi_we     = (state == S_DONE) && !bus.flush;
  assign bus.lo_we     = (state == S_DONE) && !bus.flush;
  assign bus.hi_result = hi_q;
  assign bus.lo_result = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit. Each operation is issued by
// run_op, which then watches the outputs for a fixed window of cycles after the
// accepting edge and records busy/write-strobe timing and the written values.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int WIN = MULDIV_LAT + 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observations from the last run_op
  logic [W-1:0] r_hi, r_lo;
  int r_we_k, r_we_n, r_busy, r_pair_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op; cycle k=1 is the cycle right after the accepting edge.
  // mut_k  : cycle at which operands are overwritten
  // pulse_k: cycle at which a second start is pulsed
  // flush_k: cycle at which flush is driven (0 = together with start)
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int mut_k, input int pulse_k, input int flush_k);
    r_hi = '0; r_lo = '0; r_we_k = -1; r_we_n = 0; r_busy = 0; r_pair_bad = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.flush  = (flush_k == 0);
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) r_busy++;
      if (bus.hi_we !== bus.lo_we) r_pair_bad++;
      if (bus.hi_we === 1'b1) begin
        r_we_n++;
        r_we_k = k;
        r_hi   = bus.hi_result;
        r_lo   = bus.lo_result;
      end
      bus.start = (k == pulse_k);
      bus.flush = (k == flush_k);
      if (k == pulse_k) begin
        bus.op     = OP_DIVU;
        bus.rs_val = 32'h0000_0005;
        bus.rt_val = 32'h0000_0001;
      end
      if (k == mut_k) begin
        bus.rs_val = 32'hDEAD_BEEF;
        bus.rt_val = 32'h0000_0003;
      end
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = OP_MULT;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.hi_acc = '0;
    bus.lo_acc = '0;
    bus.flush  = 1'b0;

    // Reset state
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_hi_we", bus.hi_we, 0);
    check("rst_lo_we", bus.lo_we, 0);
    check("rst_hi", bus.hi_result, 0);
    check("rst_lo", bus.lo_result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. MULTU max*max, full timing
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    check("multu_hi", r_hi, 32'hFFFF_FFFE);
    check("multu_lo", r_lo, 32'h0000_0001);
    check("multu_we_cycle", r_we_k, MULDIV_LAT);
    check("multu_we_count", r_we_n, 1);
    check("multu_busy_cycles", r_busy, MULDIV_LAT);
    check("multu_we_pair", r_pair_bad, 0);
    check("multu_hold_hi", bus.hi_result, 32'hFFFF_FFFE);

    // 2. MULT -3 * 7
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, -1, -1, -1);
    check("mult_hi", r_hi, 32'hFFFF_FFFF);
    check("mult_lo", r_lo, 32'hFFFF_FFEB);

    // 3. DIV -7/2, DIVU 7/0, DIV -5/0
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1, -1);
    check("div_neg_lo", r_lo, 32'hFFFF_FFFD);
    check("div_neg_hi", r_hi, 32'hFFFF_FFFF);
    check("div_neg_we_cycle", r_we_k, MULDIV_LAT);
    run_op(OP_DIVU, 32'h0000_0007, 32'h0000_0000, -1, -1, -1);
    check("divu0_lo", r_lo, DIV0_LO);
    check("divu0_hi", r_hi, 32'h0000_0007);
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'h0000_0000, -1, -1, -1);
    check("div0_lo", r_lo, 32'hFFFF_FFFF);
    check("div0_hi", r_hi, 32'hFFFF_FFFB);

    // 4. Signed overflow; DIVU with operands changed mid-op
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    check("div_ovf_lo", r_lo, 32'h8000_0000);
    check("div_ovf_hi", r_hi, 32'h0000_0000);
    run_op(OP_DIVU, 32'd100, 32'd7, 5, -1, -1);
    check("divu_mut_lo", r_lo, 32'd14);
    check("divu_mut_hi", r_hi, 32'd2);

    // 5. Start while busy ignored; flush mid-op; flush with start in IDLE
    run_op(OP_MULT, 32'd6, 32'd7, -1, 10, -1);
    check("pulse_lo", r_lo, 32'd42);
    check("pulse_hi", r_hi, 32'd0);
    check("pulse_we_count", r_we_n, 1);
    check("pulse_busy_cycles", r_busy, MULDIV_LAT);

    run_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010, -1, -1, 10);
    check("flush_busy_cycles", r_busy, 10);
    check("flush_we_count", r_we_n, 0);
    check("flush_hold_lo", bus.lo_result, 32'd42);

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, -1, -1, 0);
    check("flush_start_lo", r_lo, 32'hFFFF_FFFD);
    check("flush_start_hi", r_hi, 32'h0000_0001);
    check("flush_start_we_count", r_we_n, 1);

    // Asynchronous reset mid-op
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = OP_MULTU;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd5;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_hi_we", bus.hi_we, 0);
    check("arst_hi", bus.hi_result, 0);
    check("arst_lo", bus.lo_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r_we_n = 0;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      if (bus.hi_we === 1'b1 || bus.lo_we === 1'b1 || bus.busy === 1'b1) r_we_n++;
    end
    check("arst_no_activity", r_we_n, 0);

    // 6. Accumulate op
    bus.hi_acc = 32'h0000_0001;
    bus.lo_acc = 32'hFFFF_FFFF;
    run_op(OP_MADD, 32'd2, 32'd3, -1, -1, -1);
`ifdef MULDIV_MADD_EN
    check("madd_hi", r_hi, 32'h0000_0002);
    check("madd_lo", r_lo, 32'h0000_0005);
    check("madd_we_cycle", r_we_k, MULDIV_LAT);
`else
    check("madd_off_busy", r_busy, 0);
    check("madd_off_we_count", r_we_n, 0);
    check("madd_off_hold", bus.lo_result, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
